oam_dma: RTL and testbench



---
 rtl/oam_dma.sv | 132 +++++++++++++
 tb/tb_oam_dma.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Sprite-memory DMA: a write to the trigger register halts the core and copies
// one 256-byte CPU page into the OAM data port, one read and one write per byte.
module oam_dma #(
   parameter logic [15:0] P_reg_addr = 16'h4014,
   parameter logic [15:0] P_dst_addr = 16'h2004
) (
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic        I_phy2,
   input  logic [15:0] I_cpu_addr,
   input  logic        I_cpu_rdwr,
   input  logic [7:0]  I_cpu_wr_data,
   output logic        O_cpu_ready,
   output logic        O_bus_own,
   output logic [15:0] O_bus_addr,
   output logic        O_bus_rdwr,
   output logic [7:0]  O_bus_wr_data,
   input  logic [7:0]  I_bus_rd_data,
   output logic        O_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   typedef struct packed {
      logic [15:0] addr;
      logic        rdwr;
      logic [7:0]  wr_data;
   } bus_req_t;

   localparam bus_req_t C_BUS_IDLE = '{addr: 16'h0000, rdwr: 1'b1, wr_data: 8'h00};

   state_t   state, state_nxt;
   logic     R_parity;
   logic [7:0] R_page, R_index, R_data;
   logic [7:0] page_nxt, index_nxt, data_nxt;
   logic     ready_nxt, own_nxt, busy_nxt;
   bus_req_t req_nxt, req_q;
   logic     trig;

   assign trig = I_phy2 & ~I_cpu_rdwr & (I_cpu_addr == P_reg_addr);

   // State, datapath and output registers; nothing moves without a strobe
   // except the outputs, which only ever follow a strobe-driven transition.
   always_ff @(posedge I_clock or posedge I_reset) begin
      if (I_reset) begin
         state       <= S_IDLE;
         R_parity    <= 1'b0;
         R_page      <= 8'h00;
         R_index     <= 8'h00;
         R_data      <= 8'h00;
         O_cpu_ready <= 1'b1;
         O_bus_own   <= 1'b0;
         O_busy      <= 1'b0;
         req_q       <= C_BUS_IDLE;
      end else begin
         state       <= state_nxt;
         if (I_phy2)
            R_parity <= ~R_parity;
         R_page      <= page_nxt;
         R_index     <= index_nxt;
         R_data      <= data_nxt;
         O_cpu_ready <= ready_nxt;
         O_bus_own   <= own_nxt;
         O_busy      <= busy_nxt;
         req_q       <= req_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      page_nxt  = R_page;
      index_nxt = R_index;
      data_nxt  = R_data;
      if (I_phy2) begin
         case (state)
            S_IDLE: begin
               if (trig) begin
                  page_nxt  = I_cpu_wr_data;
                  index_nxt = 8'h00;
                  state_nxt = S_HALT;
               end
            end
            // R_parity is the parity of the cycle now ending; the first read
            // must land on a get (parity 0) cycle.
            S_HALT:  state_nxt = R_parity ? S_READ : S_ALIGN;
            S_ALIGN: state_nxt = S_READ;
            S_READ: begin
               data_nxt  = I_bus_rd_data;
               state_nxt = S_WRITE;
            end
            S_WRITE: begin
               index_nxt = R_index + 8'h01;
               state_nxt = (R_index == 8'hFF) ? S_IDLE : S_READ;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      ready_nxt = (state_nxt == S_IDLE);
      busy_nxt  = (state_nxt != S_IDLE);
      own_nxt   = 1'b0;
      req_nxt   = C_BUS_IDLE;
      case (state_nxt)
         S_READ: begin
            own_nxt      = 1'b1;
            req_nxt.addr = {page_nxt, index_nxt};
            req_nxt.rdwr = 1'b1;
         end
         S_WRITE: begin
            own_nxt         = 1'b1;
            req_nxt.addr    = P_dst_addr;
            req_nxt.rdwr    = 1'b0;
            req_nxt.wr_data = data_nxt;
         end
         default: ;
      endcase
   end

   assign O_bus_addr    = req_q.addr;
   assign O_bus_rdwr    = req_q.rdwr;
   assign O_bus_wr_data = req_q.wr_data;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes expected reads, writes and
// halt lengths from a cycle-count model; a negedge monitor pops and compares.
module tb_oam_dma;

   logic        I_clock = 1'b0;
   logic        I_reset = 1'b0;
   logic        I_phy2 = 1'b0;
   logic [15:0] I_cpu_addr = 16'h0000;
   logic        I_cpu_rdwr = 1'b1;
   logic [7:0]  I_cpu_wr_data = 8'h00;
   logic        O_cpu_ready, O_bus_own, O_bus_rdwr, O_busy;
   logic [15:0] O_bus_addr;
   logic [7:0]  O_bus_wr_data, I_bus_rd_data;

   logic [7:0]  mem [0:65535];
   assign I_bus_rd_data = mem[O_bus_addr];

   oam_dma dut (
      .I_clock(I_clock), .I_reset(I_reset), .I_phy2(I_phy2),
      .I_cpu_addr(I_cpu_addr), .I_cpu_rdwr(I_cpu_rdwr), .I_cpu_wr_data(I_cpu_wr_data),
      .O_cpu_ready(O_cpu_ready), .O_bus_own(O_bus_own), .O_bus_addr(O_bus_addr),
      .O_bus_rdwr(O_bus_rdwr), .O_bus_wr_data(O_bus_wr_data),
      .I_bus_rd_data(I_bus_rd_data), .O_busy(O_busy)
   );

   always #5 I_clock = ~I_clock;

   int n_chk = 0, n_pass = 0;
   logic [15:0] rd_q[$];
   logic [7:0]  wd_q[$];
   int          len_q[$];

   // model: bus cycles counted from reset; even index = get cycle
   int bus_cyc = 0, end_cyc = -1, cur_rs = 0, ratio = 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_chk++;
      $display("FAIL %s: got an unexpected bus event, expected none", name);
   endtask

   task automatic model_trig(input logic [7:0] page);
      int n, rs;
      n = bus_cyc;
      if (n > end_cyc) begin
         rs = n + 2;
         if (rs % 2 != 0) rs++;
         cur_rs  = rs;
         end_cyc = rs + 511;
         len_q.push_back(end_cyc - n);
         for (int i = 0; i < 256; i++) begin
            rd_q.push_back({page, 8'(i)});
            wd_q.push_back(mem[{page, 8'(i)}]);
         end
      end
   endtask

   task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
      for (int k = 0; k < ratio; k++) begin
         I_phy2 = (k == ratio - 1);
         I_cpu_addr = a; I_cpu_rdwr = rw; I_cpu_wr_data = d;
         if (k == ratio - 1 && !rw && a == 16'h4014) model_trig(d);
         @(posedge I_clock); #1;
      end
      I_phy2 = 1'b0;
      bus_cyc++;
   endtask

   task automatic idle_cycle();
      logic [15:0] a;
      a = 16'($urandom);
      if (a == 16'h4014) a = 16'h4015;
      bus_cycle(a, 1'($urandom), 8'($urandom));
   endtask

   task automatic trigger(input logic [7:0] page);
      bus_cycle(16'h4014, 1'b0, page);
   endtask

   task automatic align_to(input int par);
      while (bus_cyc % 2 != par) idle_cycle();
   endtask

   task automatic run_transfer(input logic [7:0] page, input bit spur, input bit hit_end);
      trigger(page);
      while (bus_cyc < end_cyc)
         if (spur && $urandom_range(0, 31) == 0) trigger(8'h07);
         else idle_cycle();
      if (hit_end) trigger(8'h07);
      else idle_cycle();
      repeat (3) idle_cycle();
   endtask

   task automatic do_reset();
      I_phy2 = 1'b0;
      I_reset = 1'b1;
      #1;
      chk("rst_ready", O_cpu_ready, 1);
      chk("rst_own", O_bus_own, 0);
      chk("rst_busy", O_busy, 0);
      chk("rst_addr", O_bus_addr, 0);
      chk("rst_rdwr", O_bus_rdwr, 1);
      chk("rst_wdata", O_bus_wr_data, 0);
      repeat (2) @(posedge I_clock);
      #1;
      I_reset = 1'b0;
      bus_cyc = 0;
      end_cyc = -1;
   endtask

   // monitor
   logic        p_valid = 1'b0, p_phy2 = 1'b0, p_ready = 1'b1;
   logic [27:0] p_outs = '0;
   int          low_cnt = 0;

   initial forever begin
      @(negedge I_clock);
      if (I_reset) begin
         rd_q.delete(); wd_q.delete(); len_q.delete();
         low_cnt = 0;
         p_valid = 1'b0;
      end else begin
         chk("busy_vs_ready", O_busy, !O_cpu_ready);
         if (!O_bus_own) begin
            chk("free_addr", O_bus_addr, 0);
            chk("free_rdwr", O_bus_rdwr, 1);
            chk("free_wdata", O_bus_wr_data, 0);
         end else
            chk("own_busy", O_busy, 1);
         if (p_valid && !p_phy2)
            chk("hold", {O_cpu_ready, O_bus_own, O_busy, O_bus_addr, O_bus_rdwr, O_bus_wr_data}, p_outs);
         if (p_valid && O_cpu_ready && !p_ready) begin
            if (len_q.size() == 0) fail("halt_len");
            else chk("halt_len", low_cnt, len_q.pop_front());
            low_cnt = 0;
         end
         if (I_phy2) begin
            if (!O_cpu_ready) low_cnt++;
            if (O_bus_own) begin
               if (O_bus_rdwr) begin
                  if (rd_q.size() == 0) fail("rd_addr");
                  else chk("rd_addr", O_bus_addr, rd_q.pop_front());
               end else begin
                  if (wd_q.size() == 0) fail("wr_data");
                  else begin
                     chk("wr_addr", O_bus_addr, 16'h2004);
                     chk("wr_data", O_bus_wr_data, wd_q.pop_front());
                  end
               end
            end
         end
         p_valid = 1'b1;
      end
      p_phy2  = I_phy2;
      p_ready = O_cpu_ready;
      p_outs  = {O_cpu_ready, O_bus_own, O_busy, O_bus_addr, O_bus_rdwr, O_bus_wr_data};
   end

   initial begin
      for (int a = 0; a < 65536; a++)
         mem[a] = (a[15:8] == 8'h02) ? (a[7:0] ^ 8'h5A) : 8'($urandom);
      #3;
      do_reset();
      repeat (3) idle_cycle();

      // even alignment, then odd alignment with ignored retriggers
      align_to(0);
      run_transfer(8'h02, 1'b0, 1'b0);
      align_to(1);
      run_transfer(8'h02, 1'b1, 1'b0);

      // trigger coinciding with the final write strobe is dropped
      align_to(0);
      run_transfer(8'h02, 1'b1, 1'b1);

      // reset after the 100th write, then a clean full copy
      align_to(1);
      trigger(8'h02);
      while (bus_cyc < cur_rs + 200) idle_cycle();
      do_reset();
      repeat (2) idle_cycle();
      run_transfer(8'h03, 1'b0, 1'b0);

      // page wrap, followed by a transfer that must start at index 0 again
      run_transfer(8'hFF, 1'b0, 1'b0);
      run_transfer(8'h20, 1'b0, 1'b0);

      // slow strobe, both alignments
      ratio = 3;
      align_to(0);
      run_transfer(8'h02, 1'b1, 1'b0);
      align_to(1);
      run_transfer(8'h02, 1'b0, 1'b1);

      // randomized ratio, gap, page and retriggers
      for (int t = 0; t < 6; t++) begin
         ratio = $urandom_range(1, 3);
         repeat ($urandom_range(0, 3)) idle_cycle();
         run_transfer(8'($urandom), 1'b1, 1'($urandom));
      end

      repeat (4) idle_cycle();
      chk("rd_q_drained", rd_q.size(), 0);
      chk("wd_q_drained", wd_q.size(), 0);
      chk("len_q_drained", len_q.size(), 0);
      chk("end_ready", O_cpu_ready, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
